// File: rtl/core_seq_ctrl_if.sv
// Fetch and data-memory handshake bundle between the sequencer and its memory ports.
interface core_seq_ctrl_if;
    logic ifu_req_o;
    logic ifu_ready_i;
    logic lsu_req_o;
    logic lsu_we_o;
    logic lsu_ready_i;

    modport master (
        output ifu_req_o, lsu_req_o, lsu_we_o,
        input  ifu_ready_i, lsu_ready_i
    );

    modport slave (
        input  ifu_req_o, lsu_req_o, lsu_we_o,
        output ifu_ready_i, lsu_ready_i
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32 core sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT control FSM.
// Optional macro CORE_SEQ_WDOG_EN adds an 8-bit FETCH/MEM wait watchdog.
module core_seq_ctrl (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    core_seq_ctrl_if.master       bus,
    input  logic [6:0]            opcode_i,
    input  logic                  ebreak_i,
    output logic                  ir_we_o,
    output logic                  pc_we_o,
    output logic                  rf_we_o,
    output logic [2:0]            imm_src_o,
    output logic                  halt_o,
    output logic                  err_o,
    output logic [31:0]           instret_o
);
    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        K_ALU    = 2'd0,
        K_LOAD   = 2'd1,
        K_STORE  = 2'd2,
        K_BRANCH = 2'd3
    } kind_e;

    state_e             state_q, state_d;
    kind_e              kind_q, kind_d;
    logic [2:0]         imm_q, imm_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               ifu_req_q, ifu_req_d;
    logic               lsu_req_q, lsu_req_d;
    logic               lsu_we_q, lsu_we_d;
    logic               pc_we_q, pc_we_d;
    logic               rf_we_q, rf_we_d;
    logic               halt_q, halt_d;

    logic [2:0]         dec_imm;
    kind_e              dec_kind;
    logic               dec_legal;
    logic               dec_brk;
    logic               wdog_expired;

    // Opcode decode: immediate format and instruction class
    always_comb begin
        dec_imm   = 3'b000;
        dec_kind  = K_ALU;
        dec_legal = 1'b1;
        dec_brk   = 1'b0;
        unique case (opcode_i)
            OP_LOAD:           begin dec_imm = 3'b001; dec_kind = K_LOAD;   end
            OP_OPIMM, OP_JALR: dec_imm = 3'b001;
            OP_STORE:          begin dec_imm = 3'b010; dec_kind = K_STORE;  end
            OP_BRANCH:         begin dec_imm = 3'b011; dec_kind = K_BRANCH; end
            OP_LUI, OP_AUIPC:  dec_imm = 3'b100;
            OP_JAL:            dec_imm = 3'b101;
            OP_OP:             dec_imm = 3'b000;
            OP_SYSTEM:         begin dec_legal = 1'b0; dec_brk = ebreak_i; end
            default:           dec_legal = 1'b0;
        endcase
    end

`ifdef CORE_SEQ_WDOG_EN
    logic [7:0] wdog_q, wdog_d;

    assign wdog_expired = (wdog_q == 8'hFF);

    // Counts consecutive unanswered request cycles; any other cycle clears it
    always_comb begin
        wdog_d = 8'd0;
        if (((state_q == S_FETCH) && !bus.ifu_ready_i) ||
            ((state_q == S_MEM)   && !bus.lsu_ready_i)) begin
            wdog_d = wdog_expired ? 8'd0 : wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wdog_q <= 8'd0;
        else          wdog_q <= wdog_d;
    end
`else
    assign wdog_expired = 1'b0;
`endif

    // Next state and registered outputs, computed from the state being entered
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        imm_d     = imm_q;
        err_d     = err_q;
        instret_d = instret_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.ifu_ready_i) begin
                    state_d = S_DECODE;
                end else if (wdog_expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_DECODE: begin
                imm_d  = dec_imm;
                kind_d = dec_kind;
                if (dec_brk) begin
                    state_d = S_HALT;
                    err_d   = 1'b0;
                end else if (!dec_legal) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = ((kind_q == K_LOAD) || (kind_q == K_STORE)) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.lsu_ready_i) begin
                    state_d = S_WB;
                end else if (wdog_expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        ifu_req_d = (state_d == S_FETCH);
        lsu_req_d = (state_d == S_MEM);
        lsu_we_d  = (state_d == S_MEM) && (kind_d == K_STORE);
        pc_we_d   = (state_d == S_WB);
        rf_we_d   = (state_d == S_WB) && (kind_d != K_STORE) && (kind_d != K_BRANCH);
        halt_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            kind_q    <= K_ALU;
            imm_q     <= 3'b000;
            err_q     <= 1'b0;
            instret_q <= '0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_we_q  <= 1'b0;
            pc_we_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            imm_q     <= imm_d;
            err_q     <= err_d;
            instret_q <= instret_d;
            ifu_req_q <= ifu_req_d;
            lsu_req_q <= lsu_req_d;
            lsu_we_q  <= lsu_we_d;
            pc_we_q   <= pc_we_d;
            rf_we_q   <= rf_we_d;
            halt_q    <= halt_d;
        end
    end

    // IR write must land in the same cycle the fetch data is presented
    assign ir_we_o       = (state_q == S_FETCH) && bus.ifu_ready_i;
    assign bus.ifu_req_o = ifu_req_q;
    assign bus.lsu_req_o = lsu_req_q;
    assign bus.lsu_we_o  = lsu_we_q;
    assign pc_we_o       = pc_we_q;
    assign rf_we_o       = rf_we_q;
    assign imm_src_o     = imm_q;
    assign halt_o        = halt_q;
    assign err_o         = err_q;
    assign instret_o     = instret_q;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: per-instruction expected traces built from the cycle budget rules.
module tb_core_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        ebreak = 1'b0;
    logic        ir_we, pc_we, rf_we, halt, err;
    logic [2:0]  imm_src;
    logic [31:0] instret;

    core_seq_ctrl_if bus();

    core_seq_ctrl dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .bus       (bus),
        .opcode_i  (opcode),
        .ebreak_i  (ebreak),
        .ir_we_o   (ir_we),
        .pc_we_o   (pc_we),
        .rf_we_o   (rf_we),
        .imm_src_o (imm_src),
        .halt_o    (halt),
        .err_o     (err),
        .instret_o (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected outputs for the current cycle
    bit          exp_valid = 1'b0;
    logic        e_ifu_req, e_ir_we, e_lsu_req, e_lsu_we, e_pc_we, e_rf_we, e_halt, e_err;
    logic [2:0]  e_imm;
    logic [31:0] e_instret;

    // Architectural model state
    logic [2:0]  m_imm = 3'd0;
    logic [31:0] m_instret = 32'd0;
    logic        m_err = 1'b0;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_BRK = 4, K_ILL = 5;

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                                  7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("ifu_req", 32'(bus.ifu_req_o), 32'(e_ifu_req));
            chk("ir_we",   32'(ir_we),         32'(e_ir_we));
            chk("lsu_req", 32'(bus.lsu_req_o), 32'(e_lsu_req));
            chk("lsu_we",  32'(bus.lsu_we_o),  32'(e_lsu_we));
            chk("pc_we",   32'(pc_we),         32'(e_pc_we));
            chk("rf_we",   32'(rf_we),         32'(e_rf_we));
            chk("imm_src", 32'(imm_src),       32'(e_imm));
            chk("halt",    32'(halt),          32'(e_halt));
            chk("err",     32'(err),           32'(e_err));
            chk("instret", instret,            e_instret);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void classify(input logic [6:0] op, input logic eb,
                                     output logic [2:0] imm, output int kind);
        imm = 3'b000;
        kind = K_ALU;
        case (op)
            7'b0000011: begin imm = 3'b001; kind = K_LOAD; end
            7'b0010011, 7'b1100111: imm = 3'b001;
            7'b0100011: begin imm = 3'b010; kind = K_STORE; end
            7'b1100011: begin imm = 3'b011; kind = K_BRANCH; end
            7'b0110111, 7'b0010111: imm = 3'b100;
            7'b1101111: imm = 3'b101;
            7'b0110011: imm = 3'b000;
            7'b1110011: kind = eb ? K_BRK : K_ILL;
            default:    kind = K_ILL;
        endcase
    endfunction

    task automatic set_exp(input logic ifu, input logic irw, input logic lsu, input logic we,
                           input logic pc, input logic rf, input logic hlt);
        e_ifu_req = ifu; e_ir_we = irw; e_lsu_req = lsu; e_lsu_we = we;
        e_pc_we = pc; e_rf_we = rf; e_halt = hlt;
        e_imm = m_imm; e_err = m_err; e_instret = m_instret;
        exp_valid = 1'b1;
    endtask

    task automatic tick(input logic fr, input logic lr, input logic [6:0] op, input logic eb);
        bus.ifu_ready_i = fr;
        bus.lsu_ready_i = lr;
        opcode = op;
        ebreak = eb;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_r(input logic fr, input logic lr);
        tick(fr, lr, 7'($urandom), 1'($urandom));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifu_req"}, 32'(bus.ifu_req_o), 32'd0);
        chk({tag, "_lsu_req"}, 32'(bus.lsu_req_o), 32'd0);
        chk({tag, "_lsu_we"},  32'(bus.lsu_we_o),  32'd0);
        chk({tag, "_we"},      32'({ir_we, pc_we, rf_we}), 32'd0);
        chk({tag, "_imm"},     32'(imm_src), 32'd0);
        chk({tag, "_halt"},    32'({halt, err}), 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    // Held reset (already asserted by caller or here), then one IDLE cycle
    task automatic do_reset();
        exp_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        m_imm = 3'd0; m_instret = 32'd0; m_err = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0);
        tick_r(rb(), rb());
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_exp(0, 0, 0, 0, 0, 0, 1);
            tick_r(rb(), rb());
        end
    endtask

    // One instruction: fw fetch waits, mw memory waits; abort resets during MEM
    task automatic run_instr(input logic [6:0] op, input logic eb, input int fw, input int mw,
                             input bit abort, output bit stopped);
        logic [2:0] imm;
        int kind;
        bit is_mem;
        classify(op, eb, imm, kind);
        stopped = 1'b0;
        for (int i = 0; i < fw; i++) begin
            set_exp(1, 0, 0, 0, 0, 0, 0);
            tick_r(1'b0, rb());
        end
        set_exp(1, 1, 0, 0, 0, 0, 0);
        tick_r(1'b1, rb());
        set_exp(0, 0, 0, 0, 0, 0, 0);
        tick(rb(), rb(), op, eb);
        m_imm = imm;
        if (kind == K_BRK || kind == K_ILL) begin
            m_err = (kind == K_ILL);
            stopped = 1'b1;
            return;
        end
        set_exp(0, 0, 0, 0, 0, 0, 0);
        tick_r(rb(), rb());
        is_mem = (kind == K_LOAD) || (kind == K_STORE);
        if (is_mem) begin
            for (int i = 0; i < mw; i++) begin
                set_exp(0, 0, 1, kind == K_STORE, 0, 0, 0);
                tick_r(rb(), 1'b0);
                if (abort) begin
                    exp_valid = 1'b0;
                    chk("abort_pre_lsu_req", 32'(bus.lsu_req_o), 32'd1);
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("abort_async");
                    stopped = 1'b1;
                    return;
                end
            end
            set_exp(0, 0, 1, kind == K_STORE, 0, 0, 0);
            tick_r(rb(), 1'b1);
        end
        set_exp(0, 0, 0, 0, 1, (kind != K_STORE) && (kind != K_BRANCH), 0);
        tick_r(rb(), rb());
        m_instret = m_instret + 32'd1;
    endtask

    initial begin
        bit st;
        bus.ifu_ready_i = 1'b0;
        bus.lsu_ready_i = 1'b0;
        do_reset();

        // OP-IMM with zero-wait fetch
        run_instr(7'b0010011, 1'b0, 0, 0, 1'b0, st);
        chk("opimm_imm", 32'(imm_src), 32'd1);
        chk("opimm_instret", instret, 32'd1);

        // STORE with delayed memory ready
        run_instr(7'b0100011, 1'b0, 0, 2, 1'b0, st);
        chk("store_imm", 32'(imm_src), 32'd2);

        // LUI, JAL, BRANCH
        run_instr(7'b0110111, 1'b0, 0, 0, 1'b0, st);
        run_instr(7'b1101111, 1'b0, 1, 0, 1'b0, st);
        run_instr(7'b1100011, 1'b0, 0, 0, 1'b0, st);
        chk("seq_imm", 32'(imm_src), 32'd3);
        chk("seq_instret", instret, 32'd5);

        for (int n = 0; n < 60; n++) begin
            run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0, st);
        end

        // Longest fetch wait still within the watchdog budget
        run_instr(7'b0110011, 1'b0, 255, 0, 1'b0, st);

        // Reset while a load is outstanding in MEM
        run_instr(7'b0000011, 1'b0, 0, 3, 1'b1, st);
        do_reset();
        chk("post_abort_ifu_req", 32'(bus.ifu_req_o), 32'd1);
        chk("post_abort_instret", instret, 32'd0);
        run_instr(7'b0000011, 1'b0, 1, 1, 1'b0, st);

        // EBREAK halts cleanly and ignores later handshakes
        run_instr(7'b1110011, 1'b1, 0, 0, 1'b0, st);
        halt_cycles(12);
        chk("ebreak_halt", 32'({halt, err}), 32'b10);

        do_reset();
        run_instr(7'b1111111, 1'b0, 0, 0, 1'b0, st);
        halt_cycles(8);
        chk("illegal_halt", 32'({halt, err}), 32'b11);

        do_reset();
        run_instr(7'b1110011, 1'b0, 2, 0, 1'b0, st);
        halt_cycles(4);
        chk("system_noebreak_err", 32'(err), 32'd1);

        do_reset();
`ifdef CORE_SEQ_WDOG_EN
        for (int i = 0; i < 256; i++) begin
            set_exp(1, 0, 0, 0, 0, 0, 0);
            tick_r(1'b0, rb());
        end
        m_err = 1'b1;
        halt_cycles(6);
        chk("wdog_halt", 32'({halt, err}), 32'b11);
`else
        run_instr(7'b0110011, 1'b0, 300, 0, 1'b0, st);
        chk("stall_instret", instret, 32'd1);
`endif

        for (int n = 0; n < 15; n++) begin
            run_instr(legal_ops[$urandom_range(0, 8)], 1'b0, $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'b0, st);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
